// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: clog2(width), never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Full-adder cell composed of two half-adder cells.
module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder_cell u_ha0 (.A(A),  .B(B),   .S(s1), .C(c1));
  half_adder_cell u_ha1 (.A(s1), .B(Cin), .S(S),  .C(c2));

  assign Cout = c1 | c2;

endmodule

// File: rtl/half_adder_cell.sv
// Half-adder cell: single-bit sum and carry of two inputs.
module half_adder_cell (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first over WIDTH cycles, one-cycle done pulse.
//   state | meaning
//   IDLE  | waiting for start; S/C hold last result
//   RUN   | one operand bit pair added per edge
//   DONE  | done pulse; S/C valid
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_next;

  full_adder_cell u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .S   (sum_bit),
    .Cout(carry_next)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_w1
    assign s_next = sum_bit;
  end else begin : g_wn
    assign s_next = {sum_bit, s_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      C     <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          carry <= carry_next;
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            S     <= s_next;
            C     <= carry_next;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: transaction-level model plus directed vectors.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] S;
  logic         busy, done, C;

  logic         start1 = 1'b0;
  logic [0:0]   A1 = '0;
  logic [0:0]   B1 = '0;
  logic         cin1 = 1'b0;
  logic [0:0]   S1;
  logic         busy1, done1, C1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
    .busy(busy), .done(done), .S(S), .C(C)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .cin(cin1),
    .busy(busy1), .done(done1), .S(S1), .C(C1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: result is plain integer addition, revealed WIDTH edges after acceptance.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_S = '0;
  logic         m_C = 1'b0;
  logic [W:0]   m_res = '0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_S = '0; m_C = 1'b0; m_left = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_res  = {1'b0, A} + {1'b0, B} + (W+1)'(cin);
        m_left = W;
        m_busy = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        {m_C, m_S} = m_res;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_S", S, m_S);
      chk("model_C", C, m_C);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start until the DUT has accepted it (works from IDLE or from the DONE cycle).
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit ok = 1'b0;
    A = a; B = b; cin = c; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("start_accepted", ok, 1'b1);
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      step();
      lat++;
      if (busy) nbusy++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    int lat, nb, pulses, first, last, prev;
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_S", S, 8'h00);
    chk("rst_C", C, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_S1", S1, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();

    // WIDTH=1: 1+1+1 = 2'b11
    A1 = 1'b1; B1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    chk("w1_nodone", done1, 1'b0);
    step();
    chk("w1_done", done1, 1'b1);
    chk("w1_S", S1, 1'b1);
    chk("w1_C", C1, 1'b1);
    step();
    chk("w1_done_clr", done1, 1'b0);
    chk("w1_busy_clr", busy1, 1'b0);

    // FF + 01: latency and busy length
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(lat, nb);
    chk("ff01_latency", lat, W);
    chk("ff01_busy_cycles", nb, W + 1);
    chk("ff01_S", S, 8'h00);
    chk("ff01_C", C, 1'b1);
    step();
    chk("ff01_idle_busy", busy, 1'b0);
    chk("ff01_idle_done", done, 1'b0);

    // 5A + A5 + 1, then 3C + 42 back-to-back
    start_op(8'h5A, 8'hA5, 1'b1);
    wait_done(lat, nb);
    chk("5aa5_S", S, 8'h00);
    chk("5aa5_C", C, 1'b1);
    start_op(8'h3C, 8'h42, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_S_hold", S, 8'h00);
      step();
    end
    wait_done(lat, nb);
    chk("3c42_S", S, 8'h7E);
    chk("3c42_C", C, 1'b0);
    step();
    step();

    // start during RUN is ignored
    start_op(8'h3C, 8'h42, 1'b0);
    step();
    step();
    A = 8'h11; B = 8'h22; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, nb);
    chk("ignore_S", S, 8'h7E);
    chk("ignore_C", C, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    chk("ignore_no_extra_done", pulses, 0);

    // reset at the 4th RUN edge
    start_op(8'hF0, 8'h0F, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_S", S, 8'h00);
    chk("midrst_C", C, 1'b0);
    rst = 1'b0;
    step();
    start_op(8'hF0, 8'h0F, 1'b0);
    wait_done(lat, nb);
    chk("after_rst_S", S, 8'hFF);
    chk("after_rst_C", C, 1'b0);
    step();

    // zeros
    start_op(8'h00, 8'h00, 1'b0);
    wait_done(lat, nb);
    chk("zero_S", S, 8'h00);
    chk("zero_C", C, 1'b0);
    step();

    // start held for 30 cycles
    A = 8'h01; B = 8'h02; cin = 1'b0; start = 1'b1;
    pulses = 0; first = -1; last = -1; prev = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (done) begin
        pulses++;
        if (first < 0) first = i;
        if (prev >= 0) chk("held_spacing", i - prev, W + 2);
        prev = i;
        last = i;
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 3);
    chk("held_span", last - first, 2 * (W + 2));
    chk("held_S", S, 8'h03);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
